// File: rtl/dll_pkg.sv
// Data link layer shared definitions: DLLP type codes,
// request layout and CRC16 constants used by rx and tx paths.
package dll_pkg;

    localparam logic [7:0] DLLP_TYPE_ACK = 8'h00;
    localparam logic [7:0] DLLP_TYPE_NAK = 8'h10;

    localparam logic [15:0] CRC16_POLY = 16'h100B;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef struct packed {
        logic [7:0]  dtype;
        logic [11:0] rsvd;
        logic [11:0] seq;
    } dllp_t;

    function automatic dllp_t make_dllp(
        input logic [7:0]  dtype,
        input logic [11:0] seq
    );
        dllp_t d;
        d.dtype = dtype;
        d.rsvd  = '0;
        d.seq   = seq;
        return d;
    endfunction

endpackage

// File: rtl/dllp_crc16.sv
// DLLP CRC16 over a 32-bit body, MSB first, inverted result.
// Purely combinational; evaluated on the frame being loaded.
module dllp_crc16
    import dll_pkg::*;
(
    input  logic [31:0] data,
    output logic [15:0] crc
);

    logic [15:0] c;
    logic        fb;

    // Bit-serial LFSR unrolled across all 32 body bits
    always_comb begin
        c  = CRC16_INIT;
        fb = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ CRC16_POLY;
            end
        end
        crc = ~c;
    end

endmodule

// File: rtl/dllp_tx_scheduler.sv
// ACK/NAK DLLP transmit scheduler: coalesces ACKs, prioritises
// NAKs, appends CRC16 and drives a registered valid/ready output.
module dllp_tx_scheduler
    import dll_pkg::*;
#(
    parameter int unsigned ACK_COALESCE = 4,
    parameter int unsigned ACK_LATENCY  = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] dllp_in,
    input  logic        dllp_in_valid,
    output logic        dllp_in_ready,
    output logic [47:0] dllp_out,
    output logic        dllp_out_valid,
    input  logic        dllp_out_ready,
    output logic        err_unknown_type
);

    localparam logic [3:0] COAL_TH = 4'(ACK_COALESCE);
    localparam logic [9:0] LAT_TH  = 10'(ACK_LATENCY);

    dllp_t       req;
    logic        accept;
    logic        is_ack;
    logic        is_nak;
    logic        is_unk;
    logic        unused_rsvd;

    logic        ack_pend;
    logic [11:0] ack_seq;
    logic [3:0]  ack_cnt;
    logic [9:0]  ack_timer;
    logic        nak_pend;
    logic [11:0] nak_seq;

    logic        slot_free;
    logic        ack_due;
    logic        load_nak;
    logic        load_ack;
    dllp_t       load_frame;
    logic [15:0] load_crc;

    assign req         = dllp_t'(dllp_in);
    assign unused_rsvd = ^req.rsvd;
    assign accept      = dllp_in_valid & dllp_in_ready;
    assign is_ack      = accept && (req.dtype == DLLP_TYPE_ACK);
    assign is_nak      = accept && (req.dtype == DLLP_TYPE_NAK);
    assign is_unk      = accept && !is_ack && !is_nak;

    assign slot_free = !dllp_out_valid || dllp_out_ready;
    assign ack_due   = ack_pend &&
                       (ack_cnt >= COAL_TH || ack_timer >= LAT_TH);
    assign load_nak  = slot_free && nak_pend;
    assign load_ack  = slot_free && !nak_pend && ack_due;

    // Select the frame body that will be loaded this cycle
    always_comb begin
        load_frame = make_dllp(DLLP_TYPE_ACK, ack_seq);
        if (nak_pend) begin
            load_frame = make_dllp(DLLP_TYPE_NAK, nak_seq);
        end
    end

    dllp_crc16 u_crc (
        .data (load_frame),
        .crc  (load_crc)
    );

    // Input is always absorbable once out of reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dllp_in_ready <= 1'b0;
        end else begin
            dllp_in_ready <= 1'b1;
        end
    end

    // Unknown request types are dropped and flagged one cycle later
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_unknown_type <= 1'b0;
        end else begin
            err_unknown_type <= is_unk;
        end
    end

    // NAK pending entry: newest sequence number wins
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            nak_pend <= 1'b0;
            nak_seq  <= '0;
        end else if (is_nak) begin
            nak_pend <= 1'b1;
            nak_seq  <= req.seq;
        end else if (load_nak) begin
            nak_pend <= 1'b0;
        end
    end

    // ACK coalescing: a NAK acknowledges implicitly and wipes it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack_pend  <= 1'b0;
            ack_seq   <= '0;
            ack_cnt   <= '0;
            ack_timer <= '0;
        end else if (is_nak) begin
            ack_pend  <= 1'b0;
            ack_cnt   <= '0;
            ack_timer <= '0;
        end else if (is_ack) begin
            ack_pend <= 1'b1;
            ack_seq  <= req.seq;
            if (!ack_pend || load_ack) begin
                ack_cnt   <= 4'd1;
                ack_timer <= '0;
            end else begin
                if (ack_cnt != 4'hF) begin
                    ack_cnt <= ack_cnt + 4'd1;
                end
                if (ack_timer < LAT_TH) begin
                    ack_timer <= ack_timer + 10'd1;
                end
            end
        end else if (load_ack) begin
            ack_pend  <= 1'b0;
            ack_cnt   <= '0;
            ack_timer <= '0;
        end else if (ack_pend && ack_timer < LAT_TH) begin
            ack_timer <= ack_timer + 10'd1;
        end
    end

    // Output register: held while stalled, reloaded on a free slot
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dllp_out       <= '0;
            dllp_out_valid <= 1'b0;
        end else if (slot_free) begin
            if (load_nak || load_ack) begin
                dllp_out       <= {load_frame, load_crc};
                dllp_out_valid <= 1'b1;
            end else begin
                dllp_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dllp_tx_scheduler.sv
// Directed bench for dllp_tx_scheduler with a long-division
// CRC reference and a negedge monitor of accepted frames.
module tb_dllp_tx_scheduler;

    logic        clk;
    logic        reset_n;
    logic [31:0] dllp_in;
    logic        dllp_in_valid;
    logic        dllp_in_ready;
    logic [47:0] dllp_out;
    logic        dllp_out_valid;
    logic        dllp_out_ready;
    logic        err_unknown_type;

    int          checks;
    int          failures;
    int          err_cnt;
    int          n;
    logic        stable;
    logic [47:0] q[$];
    logic [47:0] exp3;

    dllp_tx_scheduler #(
        .ACK_COALESCE (4),
        .ACK_LATENCY  (64)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .dllp_in          (dllp_in),
        .dllp_in_valid    (dllp_in_valid),
        .dllp_in_ready    (dllp_in_ready),
        .dllp_out         (dllp_out),
        .dllp_out_valid   (dllp_out_valid),
        .dllp_out_ready   (dllp_out_ready),
        .err_unknown_type (err_unknown_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every frame the physical layer takes and every error pulse
    always @(negedge clk) begin
        if (reset_n && dllp_out_valid && dllp_out_ready) begin
            q.push_back(dllp_out);
        end
        if (reset_n && err_unknown_type) begin
            err_cnt++;
        end
    end

    function automatic logic [15:0] ref_crc(input logic [31:0] d);
        logic [47:0] v;
        logic [47:0] g;
        v = {d, 16'h0000} ^ {16'hFFFF, 32'h0};
        g = 48'h1100B;
        for (int i = 47; i >= 16; i--) begin
            if (v[i]) begin
                v = v ^ (g << (i - 16));
            end
        end
        return ~v[15:0];
    endfunction

    function automatic logic [47:0] frame(
        input logic [7:0]  t,
        input logic [11:0] s
    );
        logic [31:0] b;
        b = {t, 12'h000, s};
        return {b, ref_crc(b)};
    endfunction

    task automatic chk(
        input string       tag,
        input logic [47:0] got,
        input logic [47:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d);
        dllp_in       = d;
        dllp_in_valid = 1'b1;
        tick(1);
        dllp_in_valid = 1'b0;
        dllp_in       = '0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        err_cnt        = 0;
        reset_n        = 1'b0;
        dllp_in        = '0;
        dllp_in_valid  = 1'b0;
        dllp_out_ready = 1'b1;
        tick(3);
        chk("rst_in_ready", 48'(dllp_in_ready), 48'd0);
        chk("rst_out_valid", 48'(dllp_out_valid), 48'd0);
        chk("rst_out", dllp_out, 48'd0);
        chk("rst_err", 48'(err_unknown_type), 48'd0);
        reset_n = 1'b1;
        tick(1);
        chk("in_ready_up", 48'(dllp_in_ready), 48'd1);

        // four ACKs coalesce into one frame carrying the newest seq
        q.delete();
        send(32'h0000_0005);
        send(32'h0000_0006);
        send(32'h0000_0007);
        send(32'h00AB_C008);
        tick(20);
        chk("coal_count", 48'(q.size()), 48'd1);
        chk("coal_frame", q[0], frame(8'h00, 12'h008));

        // lone ACK leaves on latency timeout
        q.delete();
        send(32'h0000_0064);
        n = 1;
        while (!dllp_out_valid && n < 200) begin
            tick(1);
            n++;
        end
        chk("lat_cycle", 48'(n), 48'd66);
        chk("lat_frame", dllp_out, frame(8'h00, 12'd100));
        tick(100);
        chk("lat_count", 48'(q.size()), 48'd1);

        // NAK supersedes a pending ACK; two-cycle latency
        q.delete();
        send(32'h0000_000A);
        send(32'h1000_0009);
        chk("nak_n1_valid", 48'(dllp_out_valid), 48'd0);
        tick(1);
        chk("nak_n2_valid", 48'(dllp_out_valid), 48'd1);
        chk("nak_n2_frame", dllp_out, frame(8'h10, 12'h009));
        tick(100);
        chk("nak_count", 48'(q.size()), 48'd1);
        chk("nak_frame", q[0], frame(8'h10, 12'h009));

        // backpressure holds NAK 3; NAK 4 follows on handshake
        q.delete();
        exp3 = frame(8'h10, 12'h003);
        dllp_out_ready = 1'b0;
        send(32'h1000_0003);
        tick(1);
        chk("bp_first", dllp_out, exp3);
        send(32'h1000_0004);
        stable = 1'b1;
        repeat (19) begin
            if (dllp_out !== exp3 || dllp_out_valid !== 1'b1) begin
                stable = 1'b0;
            end
            tick(1);
        end
        chk("bp_stable", 48'(stable), 48'd1);
        dllp_out_ready = 1'b1;
        tick(1);
        chk("bp_next_valid", 48'(dllp_out_valid), 48'd1);
        chk("bp_next_frame", dllp_out, frame(8'h10, 12'h004));
        tick(1);
        chk("bp_drain", 48'(dllp_out_valid), 48'd0);
        chk("bp_count", 48'(q.size()), 48'd2);
        chk("bp_q0", q[0], exp3);
        chk("bp_q1", q[1], frame(8'h10, 12'h004));

        // unknown type: single error pulse, nothing sent
        q.delete();
        err_cnt = 0;
        send(32'h2200_0001);
        chk("unk_pulse", 48'(err_unknown_type), 48'd1);
        tick(1);
        chk("unk_clear", 48'(err_unknown_type), 48'd0);
        tick(80);
        chk("unk_pulses", 48'(err_cnt), 48'd1);
        chk("unk_count", 48'(q.size()), 48'd0);

        // seq wrap and an ACK arriving while the ACK slot loads
        q.delete();
        send(32'h0000_0FFE);
        send(32'h0000_0FFF);
        send(32'h0000_0000);
        send(32'h0000_0001);
        send(32'h0000_0002);
        tick(10);
        chk("wrap_count1", 48'(q.size()), 48'd1);
        chk("wrap_frame1", q[0], frame(8'h00, 12'h001));
        tick(80);
        chk("wrap_count2", 48'(q.size()), 48'd2);
        chk("wrap_frame2", q[1], frame(8'h00, 12'h002));

        // reset mid-operation drops pending and unaccepted state
        q.delete();
        dllp_out_ready = 1'b0;
        send(32'h1000_0007);
        tick(1);
        chk("mid_valid", 48'(dllp_out_valid), 48'd1);
        send(32'h0000_0014);
        reset_n = 1'b0;
        tick(1);
        chk("mrst_valid", 48'(dllp_out_valid), 48'd0);
        chk("mrst_in_ready", 48'(dllp_in_ready), 48'd0);
        chk("mrst_out", dllp_out, 48'd0);
        tick(2);
        reset_n        = 1'b1;
        dllp_out_ready = 1'b1;
        tick(100);
        chk("mrst_no_stale", 48'(q.size()), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
